// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master, MSB first, with multi-byte frames.
// CS, SCK and MOSI all come straight from flops; ready/busy decode registered state.
module spi_master_ctrl #(
    parameter int CLK_DIV = 5,
    parameter int DATA_W  = 8,
    parameter int CS_IDLE = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cs_keep,
    input  logic              stop,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [2:0] S_GUARD = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_HIGH  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_HOLD  = 3'd6;

    localparam int CNT_MAX = (CS_IDLE > CLK_DIV) ? CS_IDLE : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_keep;
    logic              r_cs;
    logic              r_sck;
    logic              r_mosi;
    logic              r_rx_valid;

    logic w_div_done;
    logic w_setup_done;
    logic w_guard_done;
    logic w_last_bit;

    assign w_div_done   = (r_cnt == CNT_W'(CLK_DIV - 1));
    // one extra cycle covers the CS assertion itself before the setup window
    assign w_setup_done = (r_cnt == CNT_W'(CLK_DIV));
    assign w_guard_done = (r_cnt == CNT_W'(CS_IDLE - 1));
    assign w_last_bit   = (r_bit == BIT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_GUARD;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_keep     <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                S_GUARD: begin
                    if (w_guard_done) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        r_tx    <= tx_data;
                        r_keep  <= cs_keep;
                        r_cs    <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_setup_done) begin
                        r_cnt   <= '0;
                        r_mosi  <= r_tx[DATA_W-1];
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (w_div_done) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[DATA_W-2:0], spi_miso};
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_div_done) begin
                        r_cnt <= '0;
                        r_sck <= 1'b0;
                        r_tx  <= r_tx << 1;
                        if (w_last_bit) begin
                            r_rx_data  <= r_rx;
                            r_rx_valid <= 1'b1;
                            r_mosi     <= 1'b1;
                            r_state    <= r_keep ? S_WAIT : S_HOLD;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_mosi  <= r_tx[DATA_W-2];
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (start) begin
                        r_tx    <= tx_data;
                        r_keep  <= cs_keep;
                        r_mosi  <= tx_data[DATA_W-1];
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_LOW;
                    end else if (stop) begin
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_div_done) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_state <= S_GUARD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_GUARD;
                end
            endcase
        end
    end

    assign ready    = (r_state == S_IDLE) || (r_state == S_WAIT);
    assign busy     = ~r_cs;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign spi_cs   = r_cs;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench with a timeline model of the SPI master
// and a mode-0 slave model that replies with a programmable byte.
module tb_spi_master_ctrl;

    localparam int C    = 5;
    localparam int W    = 8;
    localparam int G    = 20;
    localparam int BYTE = 2 * C * W;

    localparam int M_GUARD = 0;
    localparam int M_IDLE  = 1;
    localparam int M_BYTE  = 2;
    localparam int M_WAIT  = 3;
    localparam int M_HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cs_keep = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ready;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       spi_cs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso = 1'b1;

    int checks = 0;
    int errors = 0;
    logic run = 1'b0;

    spi_master_ctrl #(.CLK_DIV(C), .DATA_W(W), .CS_IDLE(G)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .cs_keep(cs_keep), .stop(stop), .ready(ready), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .spi_cs(spi_cs),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Slave: loads reply on CS fall and after every 8th falling edge.
    logic [7:0] reply = 8'hA5;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] cap = 8'h00;
    int rises = 0;
    int s_bits = 0;
    int cs_rises = 0;
    int rxv_cnt = 0;

    always @(negedge spi_cs) begin
        s_sh = reply;
        s_bits = 0;
        spi_miso = reply[7];
    end

    always @(posedge spi_cs) cs_rises++;

    always @(posedge spi_sck) begin
        rises++;
        s_bits++;
        cap = {cap[6:0], spi_mosi};
    end

    always @(negedge spi_sck) begin
        if (s_bits == 8) begin
            s_bits = 0;
            s_sh = reply;
        end else begin
            s_sh = {s_sh[6:0], 1'b0};
        end
        spi_miso = s_sh[7];
    end

    always @(negedge clk) if (run && rx_valid) rxv_cnt++;

    // Timeline model: outputs derived from the edge offset inside each phase.
    int n = 0;
    int mode = M_GUARD;
    int t_ref = 0;
    int pre = 0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_rx_exp = 8'h00;
    logic [7:0] m_rx_data = 8'h00;
    logic m_keep = 1'b0;
    logic m_rxv = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            mode = M_GUARD;
            t_ref = 0;
            m_rxv = 1'b0;
            m_rx_data = 8'h00;
        end else begin
            n++;
            m_rxv = 1'b0;
            case (mode)
                M_GUARD: if (n - t_ref == G) mode = M_IDLE;
                M_IDLE: if (start) begin
                    mode = M_BYTE;
                    t_ref = n;
                    pre = 1 + C;
                    m_tx = tx_data;
                    m_keep = cs_keep;
                    m_rx_exp = reply;
                end
                M_BYTE: if (n - t_ref == pre + BYTE) begin
                    m_rxv = 1'b1;
                    m_rx_data = m_rx_exp;
                    mode = m_keep ? M_WAIT : M_HOLD;
                    t_ref = n;
                end
                M_WAIT: if (start) begin
                    mode = M_BYTE;
                    t_ref = n;
                    pre = 0;
                    m_tx = tx_data;
                    m_keep = cs_keep;
                    m_rx_exp = reply;
                end else if (stop) begin
                    mode = M_HOLD;
                    t_ref = n;
                end
                M_HOLD: if (n - t_ref == C) begin
                    mode = M_GUARD;
                    t_ref = n;
                end
                default: mode = M_GUARD;
            endcase
        end
    end

    always @(negedge clk) begin
        int j;
        logic ecs, esck, emosi, erdy;
        logic [13:0] act, expv;
        if (run) begin
            ecs = (mode == M_GUARD) || (mode == M_IDLE);
            erdy = (mode == M_IDLE) || (mode == M_WAIT);
            esck = 1'b0;
            emosi = 1'b1;
            if (mode == M_BYTE) begin
                j = n - t_ref - pre;
                if (j >= 0) begin
                    esck = ((j / C) % 2) == 1;
                    emosi = m_tx[7 - j / (2 * C)];
                end
            end
            act = {spi_cs, spi_sck, spi_mosi, ready, busy, rx_valid, rx_data};
            expv = {ecs, esck, emosi, erdy, ~ecs, m_rxv, m_rx_data};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle_compare n=%0d: got %h expected %h", n, act, expv);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no event expected event within budget", nm);
    endtask

    task automatic send(input logic [7:0] d, input logic k, output int e);
        start = 1'b1;
        tx_data = d;
        cs_keep = k;
        @(negedge clk);
        start = 1'b0;
        e = n;
    endtask

    task automatic wait_rxv(output int e);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rx_valid && k < 300);
        e = n;
        if (!rx_valid) timeout("rx_valid");
    endtask

    task automatic wait_ready(output int e);
        int k;
        k = 0;
        while (!ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        e = n;
        if (!ready) timeout("ready");
    endtask

    task automatic wait_cs(input logic lvl, output int e);
        int k;
        k = 0;
        while (spi_cs !== lvl && k < 300) begin
            @(negedge clk);
            k++;
        end
        e = n;
        if (spi_cs !== lvl) timeout("spi_cs");
    endtask

    task automatic wait_rises(input int target);
        int k;
        k = 0;
        while (rises < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (rises < target) timeout("sck_rises");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, e, e2, c, c0, r, r0, v0, st;
        logic [13:0] outs;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        outs = {spi_cs, spi_sck, spi_mosi, ready, busy, rx_valid, rx_data};
        chk("reset_outputs", int'(outs), 'h2800);
        wait_ready(e);
        chk("guard_after_reset", e, 20);

        // single byte 0x81, slave returns 0xA5
        reply = 8'hA5;
        r0 = rises;
        v0 = rxv_cnt;
        send(8'h81, 1'b0, s);
        wait_rxv(e);
        chk("latency_idle", e - s, 86);
        chk("rx_data_a5", int'(rx_data), 'hA5);
        chk("mosi_81", int'(cap), 'h81);
        chk("rises_8", rises - r0, 8);
        wait_cs(1'b1, c);
        chk("cs_release_delay", c - e, 5);
        wait_ready(r);
        chk("guard_time", r - c, 20);
        chk("rxv_once", rxv_cnt - v0, 1);

        // two-byte frame
        reply = 8'h5A;
        c0 = cs_rises;
        r0 = rises;
        v0 = rxv_cnt;
        send(8'h81, 1'b1, s);
        wait_rxv(e);
        chk("frame_lat1", e - s, 86);
        chk("ready_in_wait", int'(ready), 1);
        chk("frame_mosi1", int'(cap), 'h81);
        send(8'h04, 1'b1, s2);
        wait_rxv(e2);
        chk("latency_wait", e2 - s2, 80);
        chk("frame_mosi2", int'(cap), 'h04);
        chk("frame_rx2", int'(rx_data), 'h5A);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        st = n;
        wait_cs(1'b1, c);
        chk("stop_to_cs", c - st, 5);
        chk("cs_low_frame", cs_rises - c0, 1);
        chk("frame_rises", rises - r0, 16);
        chk("frame_rxv", rxv_cnt - v0, 2);

        // start mid-byte is ignored
        wait_ready(r);
        reply = 8'h3C;
        r0 = rises;
        v0 = rxv_cnt;
        send(8'h00, 1'b0, s);
        wait_rises(r0 + 3);
        start = 1'b1;
        tx_data = 8'hFF;
        cs_keep = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rxv(e);
        chk("ignored_start_mosi", int'(cap), 'h00);
        chk("ignored_start_rx", int'(rx_data), 'h3C);
        wait_ready(r);
        repeat (10) @(negedge clk);
        chk("ignored_start_rises", rises - r0, 8);
        chk("ignored_start_rxv", rxv_cnt - v0, 1);

        // start and stop together in WAIT
        reply = 8'hC3;
        send(8'h11, 1'b1, s);
        wait_rxv(e);
        start = 1'b1;
        stop = 1'b1;
        tx_data = 8'h3C;
        cs_keep = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        s = n;
        wait_rxv(e2);
        chk("start_stop_latency", e2 - s, 80);
        chk("start_stop_mosi", int'(cap), 'h3C);
        repeat (10) @(negedge clk);
        chk("start_stop_wait", int'({ready, spi_cs}), 2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cs(1'b1, c);
        wait_ready(r);

        // reset during bit 3
        reply = 8'h96;
        r0 = rises;
        v0 = rxv_cnt;
        send(8'h55, 1'b0, s);
        wait_rises(r0 + 3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        outs = {spi_cs, spi_sck, spi_mosi, ready, busy, rx_valid, rx_data};
        chk("async_reset_outputs", int'(outs), 'h2800);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        wait_ready(r);
        chk("guard_after_midreset", r, 20);
        chk("no_partial_rxv", rxv_cnt - v0, 0);
        send(8'hE7, 1'b0, s);
        wait_rxv(e);
        chk("post_reset_latency", e - s, 86);
        chk("post_reset_mosi", int'(cap), 'hE7);
        chk("post_reset_rx", int'(rx_data), 'h96);

        // back-to-back frames
        wait_cs(1'b1, c);
        wait_ready(r);
        send(8'h69, 1'b0, s);
        checks++;
        if (s - c < 20) begin
            errors++;
            $display("FAIL cs_high_time: got %0d required >= 20", s - c);
        end
        wait_rxv(e);
        chk("b2b_mosi", int'(cap), 'h69);
        wait_ready(r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master engine, the initiator-side counterpart of the SPI slave receiver. It drives chip-select, serial clock and MOSI, and samples MISO. Mode 0, MSB first, 8-bit bytes. Multi-byte frames keep CS low between bytes. It sits between a local command/data source and an external SPI slave.

Parameters:
CLK_DIV, 5, SCK half-period in clk cycles (>=2)
DATA_W, 8, bits per transfer
CS_IDLE, 20, minimum clk cycles CS stays high before the next frame may start

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request; accepted only when ready=1
tx_data  input  DATA_W  byte to send; sampled when start is accepted
cs_keep  input  1  sampled with start; 1 = hold CS low after this byte
stop  input  1  one-cycle pulse; releases CS while in WAIT
ready  output  1  able to accept start (IDLE or WAIT)
busy  output  1  CS asserted (spi_cs==0)
rx_data  output  DATA_W  last received byte
rx_valid  output  1  one-cycle pulse, rx_data updated
spi_cs  output  1  chip select, active-low
spi_sck  output  1  serial clock, idle low
spi_mosi  output  1  master out
spi_miso  input  1  slave in

Behaviour:
- Async reset values: spi_cs=1, spi_sck=0, spi_mosi=1, rx_data=0, rx_valid=0, ready=0. State goes to GUARD with the CS_IDLE counter cleared.
- All SPI outputs are registered. There is no combinational path from inputs to outputs.
- States: GUARD, IDLE, SETUP, LOW, HIGH, WAIT, HOLD.
- GUARD: spi_cs=1. Counts CS_IDLE cycles, then goes to IDLE.
- IDLE: ready=1. When start is seen, latch tx_data into the shift register and latch cs_keep. On the next cycle spi_cs=0, then go to SETUP.
- SETUP: CS low, sck=0 for CLK_DIV cycles. This gives CS-to-first-edge setup time. Then go to LOW.
- LOW: spi_mosi=current MSB of the shift register, sck=0, for CLK_DIV cycles. Then go to HIGH.
- HIGH: spi_sck=1 for CLK_DIV cycles.
  - On the clk edge where spi_sck goes 0→1, shift spi_miso into the rx shift register LSB.
  - At the end of HIGH, sck returns to 0 and the tx register shifts left.
  - Bit counter counts DATA_W bits. After the last HIGH, go to WAIT if cs_keep, else HOLD.
- Byte end (exiting the last HIGH):
  - rx_data is loaded from the rx shift register.
  - rx_valid=1 for exactly one cycle.
  - spi_mosi returns to 1.
- WAIT: CS stays low, sck=0, ready=1.
  - start: begin the next byte directly in LOW, with no SETUP.
  - stop: go to HOLD.
  - start and stop in the same cycle: start wins and stop is ignored.
- HOLD: CS low, sck=0 for CLK_DIV cycles, then spi_cs=1 and go to GUARD.
- Ignored inputs:
  - start while ready=0 is ignored; tx_data is not re-latched.
  - stop outside WAIT is ignored.
- Timing:
  - Byte time from IDLE: 1 + CLK_DIV + 2·CLK_DIV·DATA_W cycles to the rx_valid pulse.
  - Byte time from WAIT: 2·CLK_DIV·DATA_W cycles.
  - Exactly DATA_W rising sck edges occur per byte.
- SPI timing guarantees: MOSI changes only while sck=0, at least CLK_DIV cycles before each rising edge. CS never toggles while sck=1.
- Reset mid-transfer: outputs return to idle values immediately. No rx_valid is issued for the partial byte.

Test Plan:
- CLK_DIV=5, slave model returns 0xA5; start with tx_data=0x81, cs_keep=0. Required: 8 rising sck edges, each high and low phase exactly 5 clk; MOSI bits sampled at the rises = 1000_0001; rx_valid once with rx_data=0xA5; CS high 5 cycles after the last fall; ready returns after 20 cycles.
- Two-byte frame 0x81 (cs_keep=1), then 0x04 from WAIT, then stop. Required: spi_cs stays 0 throughout both bytes; 16 sck rises; two rx_valid pulses; CS rises 5 cycles after stop.
- start pulsed mid-byte with tx_data=0xFF during a 0x00 transfer. Required: MOSI stays 0 for all 8 bits; no extra byte is sent.
- start and stop in the same cycle while in WAIT. Required: the byte is sent, CS stays low, and the frame remains in WAIT afterwards.
- rst asserted during bit 3 of a byte. Required: spi_cs=1, sck=0, mosi=1 immediately; no rx_valid; the next start after GUARD completes a byte normally.
- Back-to-back: start asserted the first cycle ready rises after a frame. Required: CS high time is at least 20 clk between frames.
